// File: rtl/vga_error_monitor.sv
// Per-channel SRAM error statistics, framed by VGA vsync: lifetime totals, last-frame sum,
// bad-frame count and sticky flags. Define VGA_ERROR_MONITOR_PEAK_EN to enable peak tracking.
module vga_error_monitor #(
  parameter int unsigned NUM_CH           = 2,
  parameter int unsigned CNT_WIDTH        = 16,
  parameter int unsigned FRAME_CNT_WIDTH  = 12,
  parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
  input  logic                                           pixel_clk,
  input  logic                                           rst_n,
  input  logic [NUM_CH-1:0]                              err_i,
  input  logic                                           vsync_i,
  input  logic                                           clr_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_i,
  output logic [CNT_WIDTH-1:0]                           total_cnt_o,
  output logic [CNT_WIDTH-1:0]                           frame_cnt_o,
  output logic                                           frame_valid_o,
  output logic [FRAME_CNT_WIDTH-1:0]                     bad_frames_o,
  output logic [NUM_CH-1:0]                              sticky_o,
  output logic [CNT_WIDTH-1:0]                           peak_o
);

  localparam int unsigned PopW = $clog2(NUM_CH + 1);
  localparam int unsigned SumW = CNT_WIDTH + PopW;
  localparam logic VsyncIdle = (VSYNC_ACTIVE_LOW != 0);

  typedef enum logic [0:0] {StUnarmed, StRun} state_e;

  state_e                     state_q;
  logic                       vsync_q;
  logic [CNT_WIDTH-1:0]       total_q [NUM_CH];
  logic [CNT_WIDTH-1:0]       acc_q, acc_d;
  logic [CNT_WIDTH-1:0]       frame_cnt_q;
  logic                       frame_valid_q;
  logic [FRAME_CNT_WIDTH-1:0] bad_frames_q;
  logic [NUM_CH-1:0]          sticky_q;

  logic            boundary;
  logic [SumW-1:0] pop, acc_sum;
  logic [CNT_WIDTH-1:0] acc_inc, pop_sat;

  // XOR with the idle level turns the raw level into an "active" flag for either polarity.
  assign boundary = (vsync_i ^ VsyncIdle) & ~(vsync_q ^ VsyncIdle);

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pop = pop + SumW'(err_i[i]);
    end
    acc_sum = SumW'(acc_q) + pop;
    acc_inc = (|acc_sum[SumW-1:CNT_WIDTH]) ? '1 : acc_sum[CNT_WIDTH-1:0];
    pop_sat = (|pop[SumW-1:CNT_WIDTH]) ? '1 : pop[CNT_WIDTH-1:0];
    // Errors on the boundary cycle open the new frame.
    acc_d   = boundary ? pop_sat : acc_inc;
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q       <= StUnarmed;
      vsync_q       <= VsyncIdle;
      acc_q         <= '0;
      frame_cnt_q   <= '0;
      frame_valid_q <= 1'b0;
      bad_frames_q  <= '0;
      sticky_q      <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) total_q[i] <= '0;
    end else begin
      vsync_q       <= vsync_i;
      frame_valid_q <= 1'b0;
      if (clr_i) begin
        state_q      <= StUnarmed;
        acc_q        <= '0;
        frame_cnt_q  <= '0;
        bad_frames_q <= '0;
        sticky_q     <= '0;
        for (int i = 0; i < int'(NUM_CH); i++) total_q[i] <= '0;
      end else begin
        acc_q    <= acc_d;
        sticky_q <= sticky_q | err_i;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (err_i[i] && (total_q[i] != '1)) total_q[i] <= total_q[i] + CNT_WIDTH'(1);
        end
        if (boundary) begin
          unique case (state_q)
            StUnarmed: state_q <= StRun;
            StRun: begin
              frame_cnt_q   <= acc_q;
              frame_valid_q <= 1'b1;
              if ((acc_q != '0) && (bad_frames_q != '1)) begin
                bad_frames_q <= bad_frames_q + FRAME_CNT_WIDTH'(1);
              end
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    total_cnt_o = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (int'(sel_i) == i) total_cnt_o = total_q[i];
    end
  end

  assign frame_cnt_o   = frame_cnt_q;
  assign frame_valid_o = frame_valid_q;
  assign bad_frames_o  = bad_frames_q;
  assign sticky_o      = sticky_q;

`ifdef VGA_ERROR_MONITOR_PEAK_EN
  logic [CNT_WIDTH-1:0] peak_q;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n || clr_i) begin
      peak_q <= '0;
    end else if (boundary && (state_q == StRun) && (acc_q > peak_q)) begin
      peak_q <= acc_q;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

endmodule

// File: tb/tb_vga_error_monitor.sv
// Directed bench for vga_error_monitor: default instance plus a 4-bit-counter instance
// sharing the same stimulus for saturation checks.
module tb_vga_error_monitor;

  localparam int FrameLen = 1000;
`ifdef VGA_ERROR_MONITOR_PEAK_EN
  localparam bit PeakEn = 1'b1;
`else
  localparam bit PeakEn = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        vsync_i   = 1'b1;
  logic        clr_i     = 1'b0;
  logic [1:0]  err_i     = 2'b00;
  logic        sel_i     = 1'b0;

  logic [15:0] total_cnt_o, frame_cnt_o, peak_o;
  logic        frame_valid_o;
  logic [11:0] bad_frames_o;
  logic [1:0]  sticky_o;

  logic [3:0]  s_total, s_frame, s_peak;
  logic        s_valid;
  logic [11:0] s_bad;
  logic [1:0]  s_sticky;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_error_monitor u_dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .err_i        (err_i),
    .vsync_i      (vsync_i),
    .clr_i        (clr_i),
    .sel_i        (sel_i),
    .total_cnt_o  (total_cnt_o),
    .frame_cnt_o  (frame_cnt_o),
    .frame_valid_o(frame_valid_o),
    .bad_frames_o (bad_frames_o),
    .sticky_o     (sticky_o),
    .peak_o       (peak_o)
  );

  vga_error_monitor #(
    .NUM_CH   (2),
    .CNT_WIDTH(4)
  ) u_sat (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .err_i        (err_i),
    .vsync_i      (vsync_i),
    .clr_i        (clr_i),
    .sel_i        (sel_i),
    .total_cnt_o  (s_total),
    .frame_cnt_o  (s_frame),
    .frame_valid_o(s_valid),
    .bad_frames_o (s_bad),
    .sticky_o     (s_sticky),
    .peak_o       (s_peak)
  );

  // Apply inputs for one cycle; outputs are read 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] e, input logic c);
    vsync_i = v;
    err_i   = e;
    clr_i   = c;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic boundary(input logic [1:0] e);
    step(1'b0, e, 1'b0);
  endtask

  // Rest of a frame after its boundary cycle: vsync low 3 more cycles, n error cycles from 10.
  task automatic body(input logic [1:0] e, input int n);
    for (int i = 0; i < FrameLen - 1; i++) begin
      step((i < 3) ? 1'b0 : 1'b1, (i >= 10 && i < 10 + n) ? e : 2'b00, 1'b0);
    end
  endtask

  task automatic do_clear();
    step(1'b1, 2'b00, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step(1'b1, 2'b11, 1'b0);
    sel_i = 1'b0;
    #1;
    n_checks++; if (total_cnt_o !== 16'd0) begin n_errs++; $display("FAIL reset total0: got %0d want 0", total_cnt_o); end
    n_checks++; if (frame_cnt_o !== 16'd0) begin n_errs++; $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt_o); end
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL reset valid: got %b want 0", frame_valid_o); end
    n_checks++; if (bad_frames_o !== 12'd0) begin n_errs++; $display("FAIL reset bad: got %0d want 0", bad_frames_o); end
    n_checks++; if (sticky_o !== 2'b00) begin n_errs++; $display("FAIL reset sticky: got %b want 00", sticky_o); end
    n_checks++; if (peak_o !== 16'd0) begin n_errs++; $display("FAIL reset peak: got %0d want 0", peak_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_clear();
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL basic arm valid: got %b want 0", frame_valid_o); end
    body(2'b00, 0);
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b1) begin n_errs++; $display("FAIL basic f1 valid: got %b want 1", frame_valid_o); end
    n_checks++; if (bad_frames_o !== 12'd0) begin n_errs++; $display("FAIL basic f1 bad: got %0d want 0", bad_frames_o); end
    body(2'b01, 5);
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL basic midframe valid: got %b want 0", frame_valid_o); end
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b1) begin n_errs++; $display("FAIL basic f2 valid: got %b want 1", frame_valid_o); end
    n_checks++; if (frame_cnt_o !== 16'd5) begin n_errs++; $display("FAIL basic f2 frame_cnt: got %0d want 5", frame_cnt_o); end
    n_checks++; if (bad_frames_o !== 12'd1) begin n_errs++; $display("FAIL basic f2 bad: got %0d want 1", bad_frames_o); end
    n_checks++; if (sticky_o !== 2'b01) begin n_errs++; $display("FAIL basic sticky: got %b want 01", sticky_o); end
    step(1'b0, 2'b00, 1'b0);
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL basic pulse width: got %b want 0", frame_valid_o); end
    sel_i = 1'b0; #1;
    n_checks++; if (total_cnt_o !== 16'd5) begin n_errs++; $display("FAIL basic total0: got %0d want 5", total_cnt_o); end
    sel_i = 1'b1; #1;
    n_checks++; if (total_cnt_o !== 16'd0) begin n_errs++; $display("FAIL basic total1: got %0d want 0", total_cnt_o); end
  endtask

  task automatic test_both_channels();
    do_clear();
    boundary(2'b00);
    body(2'b11, 3);
    boundary(2'b00);
    n_checks++; if (frame_cnt_o !== 16'd6) begin n_errs++; $display("FAIL both frame_cnt: got %0d want 6", frame_cnt_o); end
    n_checks++; if (sticky_o !== 2'b11) begin n_errs++; $display("FAIL both sticky: got %b want 11", sticky_o); end
    sel_i = 1'b0; #1;
    n_checks++; if (total_cnt_o !== 16'd3) begin n_errs++; $display("FAIL both total0: got %0d want 3", total_cnt_o); end
    sel_i = 1'b1; #1;
    n_checks++; if (total_cnt_o !== 16'd3) begin n_errs++; $display("FAIL both total1: got %0d want 3", total_cnt_o); end
  endtask

  task automatic test_saturation();
    do_clear();
    boundary(2'b00);
    body(2'b01, 20);
    boundary(2'b00);
    sel_i = 1'b0; #1;
    n_checks++; if (s_total !== 4'd15) begin n_errs++; $display("FAIL sat total0: got %0d want 15", s_total); end
    n_checks++; if (s_frame !== 4'd15) begin n_errs++; $display("FAIL sat frame_cnt: got %0d want 15", s_frame); end
    n_checks++; if (s_bad !== 12'd1) begin n_errs++; $display("FAIL sat bad: got %0d want 1", s_bad); end
    n_checks++; if (frame_cnt_o !== 16'd20) begin n_errs++; $display("FAIL wide frame_cnt: got %0d want 20", frame_cnt_o); end
  endtask

  task automatic test_boundary_err();
    do_clear();
    boundary(2'b00);
    body(2'b00, 0);
    boundary(2'b10);
    n_checks++; if (frame_cnt_o !== 16'd0) begin n_errs++; $display("FAIL bnd cur frame_cnt: got %0d want 0", frame_cnt_o); end
    body(2'b00, 0);
    boundary(2'b00);
    n_checks++; if (frame_cnt_o !== 16'd1) begin n_errs++; $display("FAIL bnd next frame_cnt: got %0d want 1", frame_cnt_o); end
    n_checks++; if (bad_frames_o !== 12'd1) begin n_errs++; $display("FAIL bnd bad: got %0d want 1", bad_frames_o); end
  endtask

  task automatic test_clear_boundary();
    do_clear();
    boundary(2'b00);
    body(2'b11, 2);
    step(1'b0, 2'b11, 1'b1);
    sel_i = 1'b0; #1;
    n_checks++; if (total_cnt_o !== 16'd0) begin n_errs++; $display("FAIL clr total0: got %0d want 0", total_cnt_o); end
    sel_i = 1'b1; #1;
    n_checks++; if (total_cnt_o !== 16'd0) begin n_errs++; $display("FAIL clr total1: got %0d want 0", total_cnt_o); end
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL clr valid: got %b want 0", frame_valid_o); end
    n_checks++; if (frame_cnt_o !== 16'd0) begin n_errs++; $display("FAIL clr frame_cnt: got %0d want 0", frame_cnt_o); end
    n_checks++; if (bad_frames_o !== 12'd0) begin n_errs++; $display("FAIL clr bad: got %0d want 0", bad_frames_o); end
    n_checks++; if (sticky_o !== 2'b00) begin n_errs++; $display("FAIL clr sticky: got %b want 00", sticky_o); end
    n_checks++; if (peak_o !== 16'd0) begin n_errs++; $display("FAIL clr peak: got %0d want 0", peak_o); end
    body(2'b00, 0);
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL clr arm valid: got %b want 0", frame_valid_o); end
    body(2'b00, 0);
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b1) begin n_errs++; $display("FAIL clr 2nd valid: got %b want 1", frame_valid_o); end
    n_checks++; if (frame_cnt_o !== 16'd0) begin n_errs++; $display("FAIL clr 2nd frame_cnt: got %0d want 0", frame_cnt_o); end
  endtask

  task automatic test_peak();
    logic [15:0] exp9;
    exp9 = PeakEn ? 16'd9 : 16'd0;
    do_clear();
    boundary(2'b00);
    body(2'b01, 4);
    boundary(2'b00);
    n_checks++; if (peak_o !== (PeakEn ? 16'd4 : 16'd0)) begin n_errs++; $display("FAIL peak f4: got %0d want %0d", peak_o, PeakEn ? 4 : 0); end
    body(2'b01, 9);
    boundary(2'b00);
    n_checks++; if (peak_o !== exp9) begin n_errs++; $display("FAIL peak f9: got %0d want %0d", peak_o, exp9); end
    body(2'b01, 2);
    boundary(2'b00);
    n_checks++; if (frame_cnt_o !== 16'd2) begin n_errs++; $display("FAIL peak f2 frame_cnt: got %0d want 2", frame_cnt_o); end
    n_checks++; if (peak_o !== exp9) begin n_errs++; $display("FAIL peak hold: got %0d want %0d", peak_o, exp9); end
  endtask

  task automatic test_reset_midframe();
    do_clear();
    boundary(2'b00);
    for (int i = 0; i < 20; i++) step((i < 3) ? 1'b0 : 1'b1, 2'b01, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 2'b00, 1'b0);
    rst_n = 1'b1;
    sel_i = 1'b0; #1;
    n_checks++; if (total_cnt_o !== 16'd0) begin n_errs++; $display("FAIL rstmid total0: got %0d want 0", total_cnt_o); end
    n_checks++; if (sticky_o !== 2'b00) begin n_errs++; $display("FAIL rstmid sticky: got %b want 00", sticky_o); end
    repeat (500) step(1'b1, 2'b00, 1'b0);
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b0) begin n_errs++; $display("FAIL rstmid arm valid: got %b want 0", frame_valid_o); end
    body(2'b00, 0);
    boundary(2'b00);
    n_checks++; if (frame_valid_o !== 1'b1) begin n_errs++; $display("FAIL rstmid valid: got %b want 1", frame_valid_o); end
    n_checks++; if (frame_cnt_o !== 16'd0) begin n_errs++; $display("FAIL rstmid frame_cnt: got %0d want 0", frame_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both_channels();
    test_saturation();
    test_boundary_err();
    test_clear_boundary();
    test_peak();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_error_monitor.md
VGA_ERROR_MONITOR -- requirements
Module: vga_error_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent error sources (one per SRAM stripe).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of error counters.
REQ-003 SHALL have parameter FRAME_CNT_WIDTH, default 12, width of bad-frame counter.
REQ-004 SHALL have parameter VSYNC_ACTIVE_LOW, default 1, polarity of vsync_i.
REQ-005 SHALL have port pixel_clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous, active-low, on pixel_clk.
REQ-007 SHALL have port err_i  input  NUM_CH  per-cycle error strobes, one bit per channel.
REQ-008 SHALL have port vsync_i  input  1  raw VGA vsync level.
REQ-009 SHALL have port clr_i  input  1  synchronous clear of all statistics.
REQ-010 SHALL have port sel_i  input  max(1,$clog2(NUM_CH))  channel select for total_cnt_o.
REQ-011 SHALL have port total_cnt_o  output  CNT_WIDTH  saturating lifetime error total of channel sel_i.
REQ-012 SHALL have port frame_cnt_o  output  CNT_WIDTH  errors summed over all channels in last completed frame.
REQ-013 SHALL have port frame_valid_o  output  1  one-cycle pulse when frame_cnt_o updates.
REQ-014 SHALL have port bad_frames_o  output  FRAME_CNT_WIDTH  saturating count of completed frames with at least one error.
REQ-015 SHALL have port sticky_o  output  NUM_CH  per-channel sticky error flag.
REQ-016 SHALL have port peak_o  output  CNT_WIDTH  maximum frame_cnt_o since reset/clear.

Function
REQ-017 SHALL register vsync_i into vsync_q each cycle; boundary = vsync_i active AND vsync_q inactive (active = low when VSYNC_ACTIVE_LOW=1).
REQ-018 SHALL keep per-channel total counters, each +1 on its err_i bit, saturating at all-ones, never wrapping.
REQ-019 SHALL drive total_cnt_o combinationally from the counter indexed by sel_i; sel_i >= NUM_CH SHALL yield 0.
REQ-020 SHALL keep frame accumulator acc += popcount(err_i) each cycle, saturating at all-ones.
REQ-021 SHALL implement states UNARMED and RUN; reset/clear enter UNARMED; first boundary moves UNARMED->RUN with no snapshot.
REQ-022 In RUN, on boundary cycle: frame_cnt_o<=acc, frame_valid_o<=1, bad_frames_o+=1 (saturating) if acc!=0; visible next cycle (latency 1).
REQ-023 On every boundary cycle (either state) acc SHALL load popcount(err_i), so errors in the boundary cycle belong to the new frame.
REQ-024 frame_valid_o SHALL be 0 on all non-boundary cycles.
REQ-025 sticky_o[i] SHALL set on err_i[i] and clear only on reset or clr_i.
REQ-026 clr_i SHALL, next cycle, zero all counters, acc, sticky_o, frame_cnt_o, peak_o, frame_valid_o and enter UNARMED; vsync_q keeps tracking.
REQ-027 clr_i coincident with boundary or err_i SHALL win: same-cycle events are discarded.

Reset
REQ-028 On rst_n=0 at clock edge: all outputs 0, all counters 0, acc 0, state UNARMED, vsync_q inactive level.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid_o until two boundaries after release.

Configuration
REQ-030 Macro VGA_ERROR_MONITOR_PEAK_EN SHALL control peak tracking.
REQ-031 With VGA_ERROR_MONITOR_PEAK_EN defined: on each RUN boundary, peak_o<=max(peak_o, acc), same cycle as frame_cnt_o.
REQ-032 Without it: no peak register synthesised, peak_o tied to 0; port list unchanged.

Verification
REQ-033 NUM_CH=2, vsync low-pulse every 1000 cycles, err_i=2'b01 for 5 cycles in frame 2 -> frame_cnt_o=5, bad_frames_o=1, frame_valid_o one cycle after boundary, sticky_o=2'b01.
REQ-034 err_i=2'b11 for 3 cycles in one frame -> frame_cnt_o=6, total_cnt_o=3 for sel_i=0 and sel_i=1.
REQ-035 CNT_WIDTH=4, err_i[0] held 20 cycles -> total_cnt_o=15, frame_cnt_o=15, no wrap.
REQ-036 err_i=2'b10 on exact boundary cycle -> counted in next frame's frame_cnt_o (1), not current (0).
REQ-037 clr_i on boundary cycle with err_i=2'b11 -> all outputs 0 next cycle, no frame_valid_o, first valid only after two further boundaries.
REQ-038 PEAK_EN defined, frames with 4, 9, 2 errors -> peak_o 4, 9, 9; undefined -> peak_o stays 0.
